// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the parametrised FIFO family.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_W_DEF = 32;
    localparam int unsigned FIFO_DEPTH_DEF  = 8;

    // Occupancy needs one extra bit so that the value DEPTH itself fits.
    function automatic int unsigned fifo_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W_DEF,
    parameter int unsigned DEPTH  = FIFO_DEPTH_DEF,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage is deliberately left unreset; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_param.sv
// Parametrised first-word-fall-through FIFO with occupancy count, thresholds,
// sticky overflow/underflow flags and synchronous flush.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = FIFO_DATA_W_DEF,
    parameter int unsigned DEPTH     = FIFO_DEPTH_DEF,
    parameter int unsigned AFULL_TH  = DEPTH - 1,
    parameter int unsigned AEMPTY_TH = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [DATA_W-1:0]            data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [DATA_W-1:0]            data_o,
    output logic                         pnding_o,
    output logic                         full_o,
    output logic                         almost_full_o,
    output logic                         almost_empty_o,
    output logic [fifo_cnt_w(DEPTH)-1:0] count_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = fifo_cnt_w(DEPTH);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    if (DATA_W < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        AEMPTY_TH >= AFULL_TH || AFULL_TH > DEPTH) begin : g_param_check
        $fatal(1, "fifo_param: illegal DATA_W/DEPTH/AFULL_TH/AEMPTY_TH combination");
    end

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              ovf_q,    ovf_d;
    logic              unf_q,    unf_d;

    logic              not_empty;
    logic              is_full;
    logic              push_acc;
    logic              pop_acc;
    logic [DATA_W-1:0] rdata;

    assign not_empty = (count_q != '0);
    assign is_full   = (count_q == DEPTH_C);

    // When full, a simultaneous pop frees the slot the push is about to use.
    assign push_acc  = push_i && (!is_full || pop_i) && !flush_i;
    assign pop_acc   = pop_i && not_empty && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (push_i && !push_acc) begin
                ovf_d = 1'b1;
            end
            if (pop_i && !not_empty) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    assign data_o         = not_empty ? rdata : '0;
    assign pnding_o       = not_empty;
    assign full_o         = is_full;
    assign almost_full_o  = (count_q >= AFULL_C);
    assign almost_empty_o = (count_q <= AEMPTY_C);
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Scenario bench for fifo_param (DATA_W=32, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1)
// using a queue scoreboard of words expected to leave the FIFO.
module tb_fifo_param;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        push_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        pop_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] data_o;
    logic        pnding_o;
    logic        full_o;
    logic        almost_full_o;
    logic        almost_empty_o;
    logic [2:0]  count_o;
    logic        overflow_o;
    logic        underflow_o;

    logic [31:0] sb[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    fifo_param #(
        .DATA_W    (32),
        .DEPTH     (4),
        .AFULL_TH  (3),
        .AEMPTY_TH (1)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .push_i         (push_i),
        .data_i         (data_i),
        .pop_i          (pop_i),
        .flush_i        (flush_i),
        .data_o         (data_o),
        .pnding_o       (pnding_o),
        .full_o         (full_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Drives one cycle of stimulus and updates the reference queue and sticky flags.
    task automatic drive(input logic p, input logic [31:0] d, input logic po, input logic fl);
        bit had;
        bit was_full;
        push_i  = p;
        data_i  = d;
        pop_i   = po;
        flush_i = fl;
        had      = sb.size() > 0;
        was_full = sb.size() == 4;
        if (fl) begin
            sb.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (po && !had) m_unf = 1'b1;
            if (p && was_full && !po) m_ovf = 1'b1;
            if (po && had) void'(sb.pop_front());
            if (p && (!was_full || po)) sb.push_back(d);
        end
        @(posedge clk_i);
        #1;
        push_i  = 1'b0;
        pop_i   = 1'b0;
        flush_i = 1'b0;
        data_i  = '0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (pnding_o !== 1'b0) begin n_err++; $display("FAIL rst_pnding: got %0b expected 0", pnding_o); end
        n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL rst_full: got %0b expected 0", full_o); end
        n_cmp++; if (almost_full_o !== 1'b0) begin n_err++; $display("FAIL rst_afull: got %0b expected 0", almost_full_o); end
        n_cmp++; if (almost_empty_o !== 1'b1) begin n_err++; $display("FAIL rst_aempty: got %0b expected 1", almost_empty_o); end
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", count_o); end
        n_cmp++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin n_err++; $display("FAIL rst_flags: got %0b%0b expected 00", overflow_o, underflow_o); end
        n_cmp++; if (data_o !== 32'h0) begin n_err++; $display("FAIL rst_data: got %0h expected 0", data_o); end
        rst_i = 1'b0;
        drive(1'b1, 32'hF2F277, 1'b0, 1'b0);
        n_cmp++; if (pnding_o !== 1'b1) begin n_err++; $display("FAIL first_pnding: got %0b expected 1", pnding_o); end
        n_cmp++; if (data_o !== 32'hF2F277) begin n_err++; $display("FAIL first_data: got %0h expected f2f277", data_o); end
        n_cmp++; if (count_o !== 3'd1) begin n_err++; $display("FAIL first_count: got %0d expected 1", count_o); end
        n_cmp++; if (almost_empty_o !== 1'b1) begin n_err++; $display("FAIL first_aempty: got %0b expected 1", almost_empty_o); end
        n_cmp++; if (data_o !== sb[0]) begin n_err++; $display("FAIL first_pop_data: got %0h expected %0h", data_o, sb[0]); end
        drive(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (pnding_o !== 1'b0) begin n_err++; $display("FAIL first_drain: got %0b expected 0", pnding_o); end
    endtask

    task automatic test_fill_overflow();
        logic [31:0] vals [4];
        vals = '{32'hA1A1, 32'hFFFF, 32'h2222, 32'h3333};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vals[i], 1'b0, 1'b0);
            n_cmp++; if (count_o !== 3'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count_o, i + 1); end
            n_cmp++; if (almost_full_o !== (i + 1 >= 3)) begin n_err++; $display("FAIL fill_afull[%0d]: got %0b expected %0b", i, almost_full_o, (i + 1 >= 3)); end
            n_cmp++; if (full_o !== (i + 1 == 4)) begin n_err++; $display("FAIL fill_full[%0d]: got %0b expected %0b", i, full_o, (i + 1 == 4)); end
            n_cmp++; if (almost_empty_o !== (i + 1 <= 1)) begin n_err++; $display("FAIL fill_aempty[%0d]: got %0b expected %0b", i, almost_empty_o, (i + 1 <= 1)); end
        end
        drive(1'b1, 32'h4444, 1'b0, 1'b0);
        n_cmp++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %0b expected 1", overflow_o); end
        n_cmp++; if (count_o !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d expected 4", count_o); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (data_o !== sb[0]) begin n_err++; $display("FAIL drain_data[%0d]: got %0h expected %0h", i, data_o, sb[0]); end
            drive(1'b0, '0, 1'b1, 1'b0);
        end
        n_cmp++; if (pnding_o !== 1'b0) begin n_err++; $display("FAIL drain_pnding: got %0b expected 0", pnding_o); end
        n_cmp++; if (data_o !== 32'h0) begin n_err++; $display("FAIL drain_zero: got %0h expected 0", data_o); end
        n_cmp++; if (overflow_o !== m_ovf) begin n_err++; $display("FAIL drain_ovf_sticky: got %0b expected %0b", overflow_o, m_ovf); end
    endtask

    task automatic test_full_push_pop();
        drive(1'b0, '0, 1'b0, 1'b1);
        n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL fpp_flush_ovf: got %0b expected 0", overflow_o); end
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0);
        n_cmp++; if (data_o !== sb[0]) begin n_err++; $display("FAIL fpp_head: got %0h expected %0h", data_o, sb[0]); end
        drive(1'b1, 32'h5555, 1'b1, 1'b0);
        n_cmp++; if (count_o !== 3'd4) begin n_err++; $display("FAIL fpp_count: got %0d expected 4", count_o); end
        n_cmp++; if (full_o !== 1'b1) begin n_err++; $display("FAIL fpp_full: got %0b expected 1", full_o); end
        n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL fpp_ovf: got %0b expected 0", overflow_o); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (data_o !== sb[0]) begin n_err++; $display("FAIL fpp_data[%0d]: got %0h expected %0h", i, data_o, sb[0]); end
            if (i == 3) begin
                n_cmp++; if (data_o !== 32'h5555) begin n_err++; $display("FAIL fpp_last: got %0h expected 5555", data_o); end
            end
            drive(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_underflow();
        drive(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (underflow_o !== 1'b1) begin n_err++; $display("FAIL unf_flag: got %0b expected 1", underflow_o); end
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL unf_count: got %0d expected 0", count_o); end
        drive(1'b1, 32'h7777, 1'b1, 1'b0);
        n_cmp++; if (count_o !== 3'd1) begin n_err++; $display("FAIL unf_pp_count: got %0d expected 1", count_o); end
        n_cmp++; if (data_o !== 32'h7777) begin n_err++; $display("FAIL unf_pp_data: got %0h expected 7777", data_o); end
        n_cmp++; if (underflow_o !== m_unf) begin n_err++; $display("FAIL unf_sticky: got %0b expected %0b", underflow_o, m_unf); end
        n_cmp++; if (data_o !== sb[0]) begin n_err++; $display("FAIL unf_pop_data: got %0h expected %0h", data_o, sb[0]); end
        drive(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        logic [31:0] exp_next;
        exp_next = 32'h100;
        drive(1'b0, '0, 1'b0, 1'b1);
        // Offset the pointers first so the run crosses the wrap point more than once.
        for (int i = 0; i < 10; i++) begin
            if (i >= 2) begin
                n_cmp++; if (data_o !== exp_next) begin n_err++; $display("FAIL wrap_data: got %0h expected %0h", data_o, exp_next); end
                exp_next++;
            end
            drive(1'b1, 32'h100 + 32'(i), (i >= 2), 1'b0);
            n_cmp++; if (count_o !== 3'(sb.size())) begin n_err++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, count_o, sb.size()); end
        end
        for (int k = 0; k < 4 && sb.size() > 0; k++) begin
            n_cmp++; if (data_o !== exp_next) begin n_err++; $display("FAIL wrap_tail: got %0h expected %0h", data_o, exp_next); end
            exp_next++;
            drive(1'b0, '0, 1'b1, 1'b0);
        end
        n_cmp++; if (pnding_o !== 1'b0) begin n_err++; $display("FAIL wrap_empty: got %0b expected 0", pnding_o); end
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h20 + 32'(i), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (count_o !== 3'd3 || overflow_o !== 1'b1) begin n_err++; $display("FAIL pre_flush: got cnt %0d ovf %0b expected cnt 3 ovf 1", count_o, overflow_o); end
        drive(1'b1, 32'h99, 1'b0, 1'b1);
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d expected 0", count_o); end
        n_cmp++; if (pnding_o !== 1'b0) begin n_err++; $display("FAIL flush_pnding: got %0b expected 0", pnding_o); end
        n_cmp++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin n_err++; $display("FAIL flush_flags: got %0b%0b expected 00", overflow_o, underflow_o); end
        n_cmp++; if (data_o !== 32'h0 || almost_empty_o !== 1'b1) begin n_err++; $display("FAIL flush_out: got data %0h aempty %0b expected 0/1", data_o, almost_empty_o); end
        drive(1'b0, '0, 1'b1, 1'b1);
        n_cmp++; if (underflow_o !== 1'b0) begin n_err++; $display("FAIL flush_pop_unf: got %0b expected 0", underflow_o); end
        drive(1'b1, 32'hAB, 1'b0, 1'b0);
        drive(1'b1, 32'hCD, 1'b0, 1'b0);
        n_cmp++; if (count_o !== 3'd2 || pnding_o !== 1'b1) begin n_err++; $display("FAIL midrst_pre: got cnt %0d pnd %0b expected 2/1", count_o, pnding_o); end
        #3;
        rst_i = 1'b1;
        #1;
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL midrst_count: got %0d expected 0", count_o); end
        n_cmp++; if (pnding_o !== 1'b0 || data_o !== 32'h0) begin n_err++; $display("FAIL midrst_out: got pnd %0b data %0h expected 0/0", pnding_o, data_o); end
        n_cmp++; if (almost_empty_o !== 1'b1) begin n_err++; $display("FAIL midrst_aempty: got %0b expected 1", almost_empty_o); end
        rst_i = 1'b0;
        sb.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        drive(1'b1, 32'hEE, 1'b0, 1'b0);
        n_cmp++; if (data_o !== 32'hEE || count_o !== 3'd1) begin n_err++; $display("FAIL postrst: got data %0h cnt %0d expected ee/1", data_o, count_o); end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_full_push_pop();
        test_underflow();
        test_wrap();
        test_flush_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
